// File: rtl/pipe_pkg.sv
// Shared types and per-boundary constants for the generic pipeline stage register.
package pipe_pkg;

  // Number of beats held by a stage (0..2).
  typedef logic [1:0] occ_t;

  // ID/EX control field indices.
  localparam int IDEX_REG_W  = 0;
  localparam int IDEX_MEM_R  = 1;
  localparam int IDEX_MEM_W  = 2;
  localparam int IDEX_WB_SEL = 3;  // two bits: 4:3
  localparam int IDEX_BRANCH = 5;

  // EX/MEM control field indices.
  localparam int EXMEM_REG_W  = 0;
  localparam int EXMEM_MEM_R  = 1;
  localparam int EXMEM_MEM_W  = 2;
  localparam int EXMEM_WB_SEL = 3;  // two bits: 4:3

  // MEM/WB control field indices.
  localparam int MEMWB_REG_W  = 0;
  localparam int MEMWB_WB_SEL = 1;  // two bits: 2:1

  // One-shot control bits per boundary: a memory access must not be
  // re-issued while the beat sits stalled in front of the memory stage.
  localparam logic [7:0] IFID_PULSE_MASK  = 8'b0000_0000;
  localparam logic [7:0] IDEX_PULSE_MASK  = 8'b0000_0000;
  localparam logic [7:0] EXMEM_PULSE_MASK = 8'b0000_0110;
  localparam logic [7:0] MEMWB_PULSE_MASK = 8'b0000_0000;

  // Beats held, from the two slot valid bits.
  function automatic occ_t occ_count(input logic m_valid, input logic s_valid);
    return {1'b0, m_valid} + {1'b0, s_valid};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One beat of storage: valid bit, control vector and data vector.
// Priority: clear > load > pulse_clr.
module pipe_slot #(
  parameter int              DATA_W     = 32,
  parameter int              CTRL_W     = 8,
  parameter logic [CTRL_W-1:0] PULSE_MASK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              clear_data,
  input  logic              pulse_clr,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Slot register: kill, refill, or drop one-shot control bits while stalled.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      // NOTE: the data flops are reset as well, so out_data reads 0 after reset;
      // this is a plain register, not a RAM, so a reset costs nothing.
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (clear_data) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end else if (pulse_clr) begin
      ctrl  <= ctrl & ~PULSE_MASK;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic stage-boundary register: valid/ready handshake, optional skid slot,
// synchronous flush and one-shot control bits. Holds only the steering logic;
// storage lives in pipe_slot.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                CTRL_W     = 8,
  parameter logic [CTRL_W-1:0] PULSE_MASK = '0,
  parameter bit                SKID       = 1'b1,
  parameter bit                CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output occ_t              occupancy
);

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;

  logic in_fire, out_fire, m_open;
  logic m_from_s, m_from_in, m_drain;
  logic flush_data;

  assign out_fire   = m_valid & out_ready;
  // M can take a new beat when empty or when its current beat leaves now.
  assign m_open     = !m_valid | out_fire;
  // Skid mode keeps out_ready off the in_ready path; single-slot mode cannot.
  assign in_ready   = SKID ? !s_valid : (!m_valid | out_ready);
  assign in_fire    = in_valid & in_ready;

  // M refill priority: skid slot first (ordering), then the input.
  assign m_from_s   = m_open & s_valid;
  assign m_from_in  = m_open & !s_valid & in_fire;
  // Released with nothing behind it: ctrl zeroed so no stale enables leak out.
  assign m_drain    = m_open & !s_valid & !in_fire;
  assign flush_data = flush & CLEAR_DATA;

  pipe_slot #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .PULSE_MASK(PULSE_MASK)
  ) u_m (
    .clk       (clk),
    .rst       (rst),
    .load      (m_from_s | m_from_in),
    .clear     (flush | m_drain),
    .clear_data(flush_data),
    .pulse_clr (m_valid & !out_ready),
    .in_ctrl   (s_valid ? s_ctrl : in_ctrl),
    .in_data   (s_valid ? s_data : in_data),
    .valid     (m_valid),
    .ctrl      (m_ctrl),
    .data      (m_data)
  );

  generate
    if (SKID) begin : g_skid
      logic s_load, s_drain;
      // Catch the input when M stays busy or is being refilled from S.
      assign s_load  = in_fire & ((m_valid & !out_fire) | m_from_s);
      assign s_drain = m_from_s & !s_load;

      pipe_slot #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .PULSE_MASK('0)
      ) u_s (
        .clk       (clk),
        .rst       (rst),
        .load      (s_load),
        .clear     (flush | s_drain),
        .clear_data(flush_data),
        .pulse_clr (1'b0),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .valid     (s_valid),
        .ctrl      (s_ctrl),
        .data      (s_data)
      );
    end else begin : g_noskid
      assign s_valid = 1'b0;
      assign s_ctrl  = '0;
      assign s_data  = '0;
    end
  endgenerate

  assign out_valid = m_valid;
  assign out_ctrl  = m_ctrl;
  assign out_data  = m_data;
  assign occupancy = occ_count(m_valid, s_valid);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: a table of per-cycle vectors for the skid variant plus
// hand-written sequences for async reset, single-slot streaming and flush.
module tb_pipe_stage_skid;

  localparam int DW = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Skid variant, data held on flush.
  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occupancy;

  // Single-slot variant, data zeroed on flush.
  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occupancy;

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .PULSE_MASK(4'b0100), .SKID(1'b1), .CLEAR_DATA(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occupancy)
  );

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .PULSE_MASK(4'b0000), .SKID(1'b0), .CLEAR_DATA(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occupancy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus and the state expected right after the following edge.
  typedef struct {
    logic          iv;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;
    logic          ordy;
    logic          fl;
    logic          ov;
    logic [CW-1:0] oc;
    logic [DW-1:0] od;
    logic          irdy;
    logic [1:0]    occ;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                              input logic ordy, input logic fl, input logic ov,
                              input logic [CW-1:0] oc, input logic [DW-1:0] od,
                              input logic irdy, input logic [1:0] occ);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.oc = oc; v.od = od; v.irdy = irdy; v.occ = occ;
    return v;
  endfunction

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_d;
  logic [11:0]   rdy_pat;
  int            sent;
  int            got;
  logic [DW-1:0] next_val;
  logic          in_f, out_f;

  initial begin
    //                iv ic    id       or fl   ov oc    od       ir occ
    // Four-beat stream, no bubbles, then drain.
    vecs[0]  = mk(1, 4'h1, 16'h0001, 1, 0,  1, 4'h1, 16'h0001, 1, 2'd1);
    vecs[1]  = mk(1, 4'h1, 16'h0002, 1, 0,  1, 4'h1, 16'h0002, 1, 2'd1);
    vecs[2]  = mk(1, 4'h1, 16'h0003, 1, 0,  1, 4'h1, 16'h0003, 1, 2'd1);
    vecs[3]  = mk(1, 4'h1, 16'h0004, 1, 0,  1, 4'h1, 16'h0004, 1, 2'd1);
    vecs[4]  = mk(0, 4'h0, 16'h0000, 1, 0,  0, 4'h0, 16'h0004, 1, 2'd0);
    // A into M, B into S, upstream changes while blocked, then A, B drain in order.
    vecs[5]  = mk(1, 4'h3, 16'h000A, 0, 0,  1, 4'h3, 16'h000A, 1, 2'd1);
    vecs[6]  = mk(1, 4'h2, 16'h000B, 0, 0,  1, 4'h3, 16'h000A, 0, 2'd2);
    vecs[7]  = mk(1, 4'h5, 16'h000C, 0, 0,  1, 4'h3, 16'h000A, 0, 2'd2);
    vecs[8]  = mk(0, 4'h0, 16'h0000, 1, 0,  1, 4'h2, 16'h000B, 1, 2'd1);
    vecs[9]  = mk(0, 4'h0, 16'h0000, 1, 0,  0, 4'h0, 16'h000B, 1, 2'd0);
    // One-shot bit 2: 0111 then 0011, 0011 while stalled.
    vecs[10] = mk(1, 4'h7, 16'h0055, 0, 0,  1, 4'h7, 16'h0055, 1, 2'd1);
    vecs[11] = mk(0, 4'h0, 16'h0000, 0, 0,  1, 4'h3, 16'h0055, 1, 2'd1);
    vecs[12] = mk(0, 4'h0, 16'h0000, 0, 0,  1, 4'h3, 16'h0055, 1, 2'd1);
    vecs[13] = mk(0, 4'h0, 16'h0000, 1, 0,  0, 4'h0, 16'h0055, 1, 2'd0);
    // Flush with two beats held; data held.
    vecs[14] = mk(1, 4'h1, 16'h0011, 0, 0,  1, 4'h1, 16'h0011, 1, 2'd1);
    vecs[15] = mk(1, 4'h2, 16'h0022, 0, 0,  1, 4'h1, 16'h0011, 0, 2'd2);
    vecs[16] = mk(1, 4'h4, 16'h0033, 0, 1,  0, 4'h0, 16'h0011, 1, 2'd0);
    // Flush with an accepted beat in the same cycle: beat dropped.
    vecs[17] = mk(1, 4'h1, 16'h0044, 0, 0,  1, 4'h1, 16'h0044, 1, 2'd1);
    vecs[18] = mk(1, 4'h2, 16'h0066, 0, 1,  0, 4'h0, 16'h0044, 1, 2'd0);
    // Back-to-back replace of M.
    vecs[19] = mk(1, 4'h1, 16'h0077, 1, 0,  1, 4'h1, 16'h0077, 1, 2'd1);
    vecs[20] = mk(1, 4'h2, 16'h0078, 1, 0,  1, 4'h2, 16'h0078, 1, 2'd1);
    vecs[21] = mk(0, 4'h0, 16'h0000, 1, 0,  0, 4'h0, 16'h0078, 1, 2'd0);
    // One-shot clears M's copy only; the beat in S keeps its bit.
    vecs[22] = mk(1, 4'h4, 16'h0090, 0, 0,  1, 4'h4, 16'h0090, 1, 2'd1);
    vecs[23] = mk(1, 4'h4, 16'h0091, 0, 0,  1, 4'h0, 16'h0090, 0, 2'd2);
    vecs[24] = mk(0, 4'h0, 16'h0000, 1, 0,  1, 4'h4, 16'h0091, 1, 2'd1);
    vecs[25] = mk(0, 4'h0, 16'h0000, 1, 0,  0, 4'h0, 16'h0091, 1, 2'd0);

    a_flush = 0; a_in_valid = 0; a_in_ctrl = '0; a_in_data = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 0;

    // Reset values while rst is high.
    #2;
    check("rst.a.in_ready",  a_in_ready, 1);
    check("rst.a.out_valid", a_out_valid, 0);
    check("rst.a.out_ctrl",  a_out_ctrl, 0);
    check("rst.a.out_data",  a_out_data, 0);
    check("rst.a.occupancy", a_occupancy, 0);
    check("rst.b.in_ready",  b_in_ready, 1);
    check("rst.b.out_valid", b_out_valid, 0);
    check("rst.b.occupancy", b_occupancy, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    check("rel.a.in_ready",  a_in_ready, 1);
    check("rel.a.out_valid", a_out_valid, 0);
    check("rel.a.out_ctrl",  a_out_ctrl, 0);
    check("rel.a.occupancy", a_occupancy, 0);

    // Table-driven vectors on the skid variant.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_in_valid  = vecs[i].iv;
      a_in_ctrl   = vecs[i].ic;
      a_in_data   = vecs[i].id;
      a_out_ready = vecs[i].ordy;
      a_flush     = vecs[i].fl;
      @(posedge clk); #1;
      check($sformatf("v%0d.out_valid", i), a_out_valid, vecs[i].ov);
      check($sformatf("v%0d.out_ctrl", i),  a_out_ctrl,  vecs[i].oc);
      check($sformatf("v%0d.out_data", i),  a_out_data,  vecs[i].od);
      check($sformatf("v%0d.in_ready", i),  a_in_ready,  vecs[i].irdy);
      check($sformatf("v%0d.occupancy", i), a_occupancy, vecs[i].occ);
    end

    // Async reset mid-operation: outputs clear before the next edge.
    @(negedge clk);
    a_flush = 0; a_in_valid = 1; a_in_ctrl = 4'h5; a_in_data = 16'h1234; a_out_ready = 0;
    @(posedge clk); #1;
    check("mid.loaded", a_out_valid, 1);
    a_in_valid = 0;
    #2 rst = 1;
    #1;
    check("mid.out_valid", a_out_valid, 0);
    check("mid.out_ctrl",  a_out_ctrl, 0);
    check("mid.out_data",  a_out_data, 0);
    check("mid.occupancy", a_occupancy, 0);
    check("mid.in_ready",  a_in_ready, 1);
    @(negedge clk);
    rst = 0;

    // Single-slot variant: continuous in_valid, toggling out_ready, scoreboard.
    rdy_pat  = 12'b0111_0100_1101;
    sent     = 0;
    got      = 0;
    next_val = 16'h0100;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      b_in_valid  = 1;
      b_in_ctrl   = 4'h1;
      b_in_data   = next_val;
      b_out_ready = rdy_pat[k];
      #1;
      check("b.occ_max", (b_occupancy <= 2'd1), 1);
      if (b_out_valid) check($sformatf("b.mirror%0d", k), b_in_ready, b_out_ready);
      in_f  = b_in_valid & b_in_ready;
      out_f = b_out_valid & b_out_ready;
      if (out_f) begin
        if (q.size() == 0) check("b.extra_beat", 1, 0);
        else begin
          exp_d = q.pop_front();
          got++;
          check($sformatf("b.data%0d", got), b_out_data, exp_d);
        end
      end
      if (in_f) begin
        q.push_back(next_val);
        sent++;
        next_val = next_val + 16'h1;
      end
    end
    // Drain, bounded.
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      @(negedge clk);
      b_in_valid  = 0;
      b_out_ready = 1;
      #1;
      if (b_out_valid) begin
        exp_d = q.pop_front();
        got++;
        check($sformatf("b.data%0d", got), b_out_data, exp_d);
      end
    end
    check("b.drained", q.size(), 0);
    check("b.count", got, sent);
    @(negedge clk);
    b_in_valid = 0; b_out_ready = 1;
    @(posedge clk); #1;
    check("b.empty", b_out_valid, 0);

    // Single-slot flush with out_fire and in_fire in the same cycle; data zeroed.
    @(negedge clk);
    b_in_valid = 1; b_in_ctrl = 4'h3; b_in_data = 16'h00AB; b_out_ready = 0;
    @(posedge clk); #1;
    check("bf.out_valid", b_out_valid, 1);
    check("bf.out_data",  b_out_data, 16'h00AB);
    check("bf.in_ready",  b_in_ready, 0);
    @(negedge clk);
    b_in_data = 16'h00CD; b_out_ready = 1; b_flush = 1;
    #1;
    check("bf.comb_ready", b_in_ready, 1);
    @(posedge clk); #1;
    check("bf.f.out_valid", b_out_valid, 0);
    check("bf.f.out_ctrl",  b_out_ctrl, 0);
    check("bf.f.out_data",  b_out_data, 0);
    check("bf.f.occupancy", b_occupancy, 0);
    @(negedge clk);
    b_flush = 0; b_in_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
